// File: rtl/complex_operand_packer_if.sv
// -----------------------------------------------------------------------------
// complex_operand_packer_if
//   Bundles the streaming input beat channel and the wide frame output channel
//   of complex_operand_packer.
//   Ports (seen from the packer, modport slave):
//     s_valid_i   in   input beat valid
//     s_ready_o   out  input beat ready
//     s_data_i    in   {b_im, b_re, a_im, a_re}, a_re in the LSBs
//     s_last_i    in   final beat of the frame
//     operands_o  out  packed frame, word[i*4+k] = element i, scalar k
//     out_valid_o out  frame valid toward the multiplier
//     out_ready_i in   multiplier accepts the frame
//     err_o       out  one-cycle framing error pulse
//     busy_o      out  a bank is full or a fill is in progress
//   The master modport is the view of the producer/consumer around the packer.
// -----------------------------------------------------------------------------
interface complex_operand_packer_if #(
  parameter int WIDTH        = 64,
  parameter int SIZE         = 16,
  parameter int NUM_OPERANDS = 4
);
  logic                                s_valid_i;
  logic                                s_ready_o;
  logic [NUM_OPERANDS*WIDTH-1:0]       s_data_i;
  logic                                s_last_i;
  logic [SIZE*NUM_OPERANDS*WIDTH-1:0]  operands_o;
  logic                                out_valid_o;
  logic                                out_ready_i;
  logic                                err_o;
  logic                                busy_o;

  modport slave (
    input  s_valid_i, s_data_i, s_last_i, out_ready_i,
    output s_ready_o, operands_o, out_valid_o, err_o, busy_o
  );

  modport master (
    output s_valid_i, s_data_i, s_last_i, out_ready_i,
    input  s_ready_o, operands_o, out_valid_o, err_o, busy_o
  );
endinterface

// File: rtl/complex_operand_packer.sv
// -----------------------------------------------------------------------------
// complex_operand_packer
//   Packs SIZE complex element-pair beats into one wide operand frame for
//   complex_matrix_mul. Two frame banks are used ping-pong so the next frame
//   can fill while the current one waits for the multiplier.
//   Ports:
//     clk_i    in  clock, rising edge
//     rst_ni   in  synchronous reset, active-low
//     flush_i  in  synchronous drop of both banks and any partial fill
//     bus      complex_operand_packer_if.slave (beat input + frame output)
// -----------------------------------------------------------------------------
module complex_operand_packer #(
  parameter int WIDTH        = 64,
  parameter int SIZE         = 16,
  parameter int NUM_OPERANDS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  complex_operand_packer_if.slave   bus
);

  localparam int BEAT_W  = NUM_OPERANDS * WIDTH;
  localparam int FRAME_W = SIZE * BEAT_W;
  localparam int CNT_W   = (SIZE > 1) ? $clog2(SIZE) : 1;

  if (NUM_OPERANDS != 4) begin : g_bad_operands
    $fatal(1, "complex_operand_packer: NUM_OPERANDS must be 4");
  end

  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               err_q, err_d;
  logic [FRAME_W-1:0] bank_q [2];

  logic s_ready;
  logic in_fire;
  logic out_fire;
  logic last_beat;
  logic close;

  // Reset is folded into ready so the source sees no acceptance while held.
  assign s_ready   = rst_ni && !full_q[wr_bank_q] && !flush_i;
  assign in_fire   = bus.s_valid_i && s_ready;
  assign out_fire  = full_q[rd_bank_q] && bus.out_ready_i && !flush_i;
  assign last_beat = (beat_cnt_q == CNT_W'(SIZE - 1));
  assign close     = in_fire && (last_beat || bus.s_last_i);

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    beat_cnt_d = beat_cnt_q;
    // A framing error is a last flag that disagrees with the beat position:
    // either early last, or a missing last on the final beat.
    err_d      = in_fire && (last_beat ^ bus.s_last_i);
    if (in_fire) begin
      if (close) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        beat_cnt_d        = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
    // Close and drain always target different banks (close needs an empty
    // bank, drain needs a full one), so both updates can apply together.
    if (out_fire) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      // Freed banks are zeroed so a short frame leaves its tail at zero.
      if (out_fire) begin
        bank_q[rd_bank_q] <= '0;
      end
      if (in_fire) begin
        for (int i = 0; i < SIZE; i++) begin
          if (beat_cnt_q == CNT_W'(i)) begin
            bank_q[wr_bank_q][i*BEAT_W +: BEAT_W] <= bus.s_data_i;
          end
        end
      end
    end
  end

  assign bus.s_ready_o   = s_ready;
  assign bus.out_valid_o = full_q[rd_bank_q];
  assign bus.operands_o  = bank_q[rd_bank_q];
  assign bus.err_o       = err_q;
  assign bus.busy_o      = full_q[0] | full_q[1] | (beat_cnt_q != '0);

endmodule
